// File: rtl/serial_add_sched.sv
// serial_add_sched: bit-serial adder sharing a single 1-bit full-adder cell
// between two requesters under round-robin arbitration.
//
// Ports:
//   clk, rst_n                      clock (rising edge), async active-low reset
//   req0_valid/a/b/cin, req0_ready  requester 0 operand handshake
//   req1_valid/a/b/cin, req1_ready  requester 1 operand handshake
//   res_valid/sum/cout/id, res_ready  result handshake, tagged with requester id
//   busy                            high while an addition is running or waiting
//                                   to be taken by the consumer
module serial_add_sched #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             req0_valid,
  input  logic [WIDTH-1:0] req0_a,
  input  logic [WIDTH-1:0] req0_b,
  input  logic             req0_cin,
  output logic             req0_ready,
  input  logic             req1_valid,
  input  logic [WIDTH-1:0] req1_a,
  input  logic [WIDTH-1:0] req1_b,
  input  logic             req1_cin,
  output logic             req1_ready,
  output logic             res_valid,
  output logic [WIDTH-1:0] res_sum,
  output logic             res_cout,
  output logic             res_id,
  input  logic             res_ready,
  output logic             busy
);

  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t           state_r;
  logic             last_grant_r;
  logic [CW-1:0]    count_r;
  logic [WIDTH-1:0] a_r;
  logic [WIDTH-1:0] b_r;
  logic [WIDTH-1:0] sum_r;
  logic             carry_r;
  logic [WIDTH-1:0] res_sum_r;
  logic             res_cout_r;
  logic             res_id_r;
  logic             res_valid_r;
  logic             busy_r;

  logic             grant_s;
  logic             any_valid_s;
  logic             fa_sum_s;
  logic             fa_cout_s;
  logic [WIDTH-1:0] sum_next_s;

  // The shared cell: returns {carry_out, sum}.
  function automatic logic [1:0] full_add(input logic a, input logic b, input logic c);
    full_add = {(a & b) | (a & c) | (b & c), a ^ b ^ c};
  endfunction

  // Round-robin grant: a lone requester wins; on a tie the one not served last wins.
  always_comb begin
    grant_s     = 1'b0;
    any_valid_s = req0_valid | req1_valid;
    if (req0_valid && req1_valid) begin
      grant_s = ~last_grant_r;
    end else if (req1_valid) begin
      grant_s = 1'b1;
    end else begin
      grant_s = 1'b0;
    end
  end

  assign req0_ready = (state_r == IDLE) && req0_valid && (grant_s == 1'b0);
  assign req1_ready = (state_r == IDLE) && req1_valid && (grant_s == 1'b1);

  // One bit of the addition per cycle; the new sum bit enters at the MSB so
  // that after WIDTH shifts the LSB-first stream lands in natural order.
  always_comb begin
    {fa_cout_s, fa_sum_s}  = full_add(a_r[0], b_r[0], carry_r);
    sum_next_s             = sum_r >> 1;
    sum_next_s[WIDTH-1]    = fa_sum_s;
  end

  // Control FSM with operand, sum and result registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r      <= IDLE;
      last_grant_r <= 1'b1;
      count_r      <= '0;
      a_r          <= '0;
      b_r          <= '0;
      sum_r        <= '0;
      carry_r      <= 1'b0;
      res_sum_r    <= '0;
      res_cout_r   <= 1'b0;
      res_id_r     <= 1'b0;
      res_valid_r  <= 1'b0;
      busy_r       <= 1'b0;
    end else begin
      case (state_r)
        IDLE: begin
          if (any_valid_s) begin
            a_r          <= grant_s ? req1_a : req0_a;
            b_r          <= grant_s ? req1_b : req0_b;
            carry_r      <= grant_s ? req1_cin : req0_cin;
            sum_r        <= '0;
            count_r      <= '0;
            res_id_r     <= grant_s;
            last_grant_r <= grant_s;
            busy_r       <= 1'b1;
            state_r      <= RUN;
          end
        end
        RUN: begin
          a_r     <= a_r >> 1;
          b_r     <= b_r >> 1;
          sum_r   <= sum_next_s;
          carry_r <= fa_cout_s;
          count_r <= count_r + CW'(1);
          if (count_r == CW'(WIDTH - 1)) begin
            // Result registers are loaded once so they stay put while the
            // next operand pair streams through the cell.
            res_sum_r   <= sum_next_s;
            res_cout_r  <= fa_cout_s;
            res_valid_r <= 1'b1;
            state_r     <= DONE;
          end
        end
        DONE: begin
          if (res_ready) begin
            res_valid_r <= 1'b0;
            busy_r      <= 1'b0;
            state_r     <= IDLE;
          end
        end
        default: begin
          res_valid_r <= 1'b0;
          busy_r      <= 1'b0;
          state_r     <= IDLE;
        end
      endcase
    end
  end

  assign res_valid = res_valid_r;
  assign res_sum   = res_sum_r;
  assign res_cout  = res_cout_r;
  assign res_id    = res_id_r;
  assign busy      = busy_r;

endmodule

// File: tb/tb_serial_add_sched.sv
// Self-checking bench for serial_add_sched: a transaction-level model checked
// every cycle against the WIDTH=8 instance, directed scenarios with literal
// expectations, and a WIDTH=1 instance exercised over the full-adder table.
module tb_serial_add_sched;

  localparam int W = 8;

  logic         clk;
  logic         rst_n;
  logic         req0_valid, req0_cin, req1_valid, req1_cin, res_ready;
  logic [W-1:0] req0_a, req0_b, req1_a, req1_b;
  logic         req0_ready, req1_ready, res_valid, res_cout, res_id, busy;
  logic [W-1:0] res_sum;

  logic         w_req0_valid, w_req0_cin, w_req1_valid, w_req1_cin, w_res_ready;
  logic [0:0]   w_req0_a, w_req0_b, w_req1_a, w_req1_b, w_res_sum;
  logic         w_req0_ready, w_req1_ready, w_res_valid, w_res_cout, w_res_id, w_busy;

  int total = 0;
  int bad   = 0;

  serial_add_sched #(.WIDTH(W)) dut (
    .clk(clk), .rst_n(rst_n),
    .req0_valid(req0_valid), .req0_a(req0_a), .req0_b(req0_b), .req0_cin(req0_cin),
    .req0_ready(req0_ready),
    .req1_valid(req1_valid), .req1_a(req1_a), .req1_b(req1_b), .req1_cin(req1_cin),
    .req1_ready(req1_ready),
    .res_valid(res_valid), .res_sum(res_sum), .res_cout(res_cout), .res_id(res_id),
    .res_ready(res_ready), .busy(busy)
  );

  serial_add_sched #(.WIDTH(1)) dut1 (
    .clk(clk), .rst_n(rst_n),
    .req0_valid(w_req0_valid), .req0_a(w_req0_a), .req0_b(w_req0_b), .req0_cin(w_req0_cin),
    .req0_ready(w_req0_ready),
    .req1_valid(w_req1_valid), .req1_a(w_req1_a), .req1_b(w_req1_b), .req1_cin(w_req1_cin),
    .req1_ready(w_req1_ready),
    .res_valid(w_res_valid), .res_sum(w_res_sum), .res_cout(w_res_cout), .res_id(w_res_id),
    .res_ready(w_res_ready), .busy(w_busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic fail_now(input string name);
    total++;
    bad++;
    $display("FAIL %s (wait bound expired) at %0t", name, $time);
  endtask

  // ---------------- transaction-level model (WIDTH=8 instance) -------------
  typedef enum {M_IDLE, M_RUN, M_DONE} mstate_t;
  mstate_t      m_st;
  int           m_left;
  logic         m_last;
  logic         m_id;
  logic [W:0]   m_pend;
  logic [W-1:0] m_sum;
  logic         m_cout;

  function automatic logic pick(input logic v0, input logic v1, input logic last);
    if (v0 && v1) return ~last;
    return v1;
  endfunction

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_st <= M_IDLE; m_left <= 0; m_last <= 1'b1; m_id <= 1'b0;
      m_pend <= '0; m_sum <= '0; m_cout <= 1'b0;
    end else begin
      case (m_st)
        M_IDLE: if (req0_valid || req1_valid) begin
          m_id   <= pick(req0_valid, req1_valid, m_last);
          m_last <= pick(req0_valid, req1_valid, m_last);
          m_pend <= pick(req0_valid, req1_valid, m_last)
                    ? (W+1)'(req1_a) + (W+1)'(req1_b) + (W+1)'(req1_cin)
                    : (W+1)'(req0_a) + (W+1)'(req0_b) + (W+1)'(req0_cin);
          m_left <= W;
          m_st   <= M_RUN;
        end
        M_RUN: begin
          m_left <= m_left - 1;
          if (m_left == 1) begin
            {m_cout, m_sum} <= m_pend;
            m_st <= M_DONE;
          end
        end
        M_DONE: if (res_ready) m_st <= M_IDLE;
        default: m_st <= M_IDLE;
      endcase
    end
  end

  // Compare every cycle, away from the rising edge.
  always @(negedge clk) begin
    check("res_valid", res_valid, m_st == M_DONE);
    check("busy", busy, m_st != M_IDLE);
    check("req0_ready", req0_ready,
          (m_st == M_IDLE) && req0_valid && !pick(req0_valid, req1_valid, m_last));
    check("req1_ready", req1_ready,
          (m_st == M_IDLE) && req1_valid && pick(req0_valid, req1_valid, m_last));
    check("res_sum", res_sum, m_sum);
    check("res_cout", res_cout, m_cout);
    check("res_id", res_id, m_id);
  end

  logic t2_active = 1'b0;
  logic r0_seen   = 1'b0;
  always @(negedge clk) if (t2_active && req0_ready) r0_seen <= 1'b1;

  // ---------------- directed stimulus ---------------------------------------
  task automatic tick;
    @(posedge clk); #1;
  endtask

  task automatic handshake(input logic id, input logic [W-1:0] a, input logic [W-1:0] b,
                           input logic c);
    logic ok;
    if (id) begin req1_a = a; req1_b = b; req1_cin = c; req1_valid = 1'b1; end
    else    begin req0_a = a; req0_b = b; req0_cin = c; req0_valid = 1'b1; end
    ok = 1'b0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if ((id ? req1_ready : req0_ready) == 1'b1) ok = 1'b1;
      @(posedge clk); #1;
      if (ok) break;
    end
    if (id) req1_valid = 1'b0; else req0_valid = 1'b0;
    if (!ok) fail_now("handshake");
  endtask

  task automatic wait_result(output int lat);
    lat = 0;
    for (int i = 0; i < 40; i++) begin
      tick();
      lat++;
      if (res_valid) break;
    end
    if (!res_valid) fail_now("wait_result");
  endtask

  task automatic issue(input logic id, input logic [W-1:0] a, input logic [W-1:0] b,
                       input logic c, output int lat);
    handshake(id, a, b, c);
    wait_result(lat);
  endtask

  task automatic do_reset;
    rst_n = 1'b0;
    tick(); tick();
    rst_n = 1'b1;
  endtask

  logic [1:0] fa_tab [8];
  initial begin
    fa_tab = '{2'b00, 2'b01, 2'b01, 2'b10, 2'b01, 2'b10, 2'b10, 2'b11};
  end

  initial begin
    #200000;
    $display("FAIL watchdog expired at %0t", $time);
    $fatal(1, "watchdog");
  end

  initial begin
    int lat;
    int n0, n1;
    logic [2:0] v;

    req0_valid = 1'b0; req0_a = '0; req0_b = '0; req0_cin = 1'b0;
    req1_valid = 1'b0; req1_a = '0; req1_b = '0; req1_cin = 1'b0;
    res_ready  = 1'b1;
    w_req0_valid = 1'b0; w_req0_a = '0; w_req0_b = '0; w_req0_cin = 1'b0;
    w_req1_valid = 1'b0; w_req1_a = '0; w_req1_b = '0; w_req1_cin = 1'b0;
    w_res_ready  = 1'b1;

    // Reset state
    rst_n = 1'b0;
    tick(); tick();
    check("rst_res_valid", res_valid, 1'b0);
    check("rst_busy", busy, 1'b0);
    check("rst_sum", res_sum, 8'h00);
    check("rst_cout", res_cout, 1'b0);
    check("rst_id", res_id, 1'b0);
    rst_n = 1'b1;
    tick();

    // 1: req0 0xFF+0x01 -> 0x00 carry 1, latency WIDTH
    issue(1'b0, 8'hFF, 8'h01, 1'b0, lat);
    check("t1_latency", lat, 8);
    check("t1_sum", res_sum, 8'h00);
    check("t1_cout", res_cout, 1'b1);
    check("t1_id", res_id, 1'b0);
    tick();
    check("t1_valid_drop", res_valid, 1'b0);

    // 2: req1 0x7F+0x80+1 -> 0x00 carry 1; req0 never ready
    t2_active = 1'b1;
    issue(1'b1, 8'h7F, 8'h80, 1'b1, lat);
    check("t2_sum", res_sum, 8'h00);
    check("t2_cout", res_cout, 1'b1);
    check("t2_id", res_id, 1'b1);
    tick();
    t2_active = 1'b0;
    check("t2_req0_ready_never", r0_seen, 1'b0);

    // 3: both valid continuously from reset, grants must alternate
    do_reset();
    n0 = 0; n1 = 0;
    req0_a = 8'h10; req0_b = 8'h20; req0_cin = 1'b0;
    req1_a = 8'h40; req1_b = 8'hC0; req1_cin = 1'b1;
    req0_valid = 1'b1; req1_valid = 1'b1;
    for (int k = 0; k < 10; k++) begin
      wait_result(lat);
      check("t3_alternate", res_id, k % 2);
      if (k == 0) check("t3_first_sum", {res_cout, res_sum}, 9'h030);
      if (k == 1) check("t3_second_sum", {res_cout, res_sum}, 9'h101);
      if (res_id) begin n1++; req1_b = 8'hC0 + 8'(n1); end
      else        begin n0++; req0_a = 8'h10 + 8'(n0); end
      tick();
    end
    req0_valid = 1'b0; req1_valid = 1'b0;
    check("t3_count0", n0, 5);
    check("t3_count1", n1, 5);
    tick(); tick(); tick(); tick(); tick(); tick(); tick(); tick(); tick(); tick(); tick();

    // 4: consumer stalls DONE for 5 cycles
    res_ready = 1'b0;
    issue(1'b0, 8'h3C, 8'h0F, 1'b1, lat);
    req0_valid = 1'b1; req1_valid = 1'b1;
    for (int k = 0; k < 5; k++) begin
      tick();
      check("t4_hold_valid", res_valid, 1'b1);
      check("t4_hold_sum", res_sum, 8'h4C);
      check("t4_hold_id", res_id, 1'b0);
      check("t4_no_ready0", req0_ready, 1'b0);
      check("t4_no_ready1", req1_ready, 1'b0);
    end
    res_ready = 1'b1; req0_valid = 1'b0; req1_valid = 1'b0;
    tick();
    check("t4_valid_drop", res_valid, 1'b0);
    check("t4_idle", busy, 1'b0);

    // 5: reset mid-RUN discards the result
    handshake(1'b0, 8'hAA, 8'h55, 1'b0);
    tick(); tick(); tick();
    rst_n = 1'b0;
    #1;
    check("t5_valid", res_valid, 1'b0);
    check("t5_busy", busy, 1'b0);
    check("t5_sum", res_sum, 8'h00);
    check("t5_cout", res_cout, 1'b0);
    tick(); tick();
    rst_n = 1'b1;
    tick(); tick();
    check("t5_no_result", res_valid, 1'b0);
    issue(1'b0, 8'h12, 8'h34, 1'b0, lat);
    check("t5_latency", lat, 8);
    check("t5_sum2", res_sum, 8'h46);
    check("t5_cout2", res_cout, 1'b0);
    tick();

    // 6: WIDTH=1 instance over the full-adder truth table
    for (int i = 0; i < 8; i++) begin
      logic ok;
      v = 3'(i);
      w_req0_a = v[2]; w_req0_b = v[1]; w_req0_cin = v[0];
      w_req0_valid = 1'b1;
      ok = 1'b0;
      for (int j = 0; j < 20; j++) begin
        @(negedge clk);
        if (w_req0_ready) ok = 1'b1;
        tick();
        if (ok) break;
      end
      w_req0_valid = 1'b0;
      if (!ok) fail_now("w1_handshake");
      lat = 0;
      for (int j = 0; j < 20; j++) begin
        tick();
        lat++;
        if (w_res_valid) break;
      end
      if (!w_res_valid) fail_now("w1_result");
      check("w1_latency", lat, 1);
      check("w1_truth", {w_res_cout, w_res_sum}, fa_tab[i]);
      tick();
      check("w1_valid_drop", w_res_valid, 1'b0);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/serial_add_sched.md
Name: serial_add_sched

Overview:
- Bit-serial addition engine that owns one 1-bit full-adder cell and shares it between two requesters.
- A round-robin arbiter accepts one operand pair at a time.
- The FSM feeds the cell LSB-first for WIDTH cycles, holding the carry in a flop between bits.
- The result is returned through a valid/ready handshake tagged with the requester ID.
- Sits between operand producers and a consumer where area matters more than throughput.

Parameters:
WIDTH, 8, operand/sum width in bits; legal range 1..32.

Ports:
clk  input  1  single clock, rising-edge.
rst_n  input  1  asynchronous active-low reset.
req0_valid  input  1  requester 0 has operands.
req0_a  input  WIDTH  requester 0 operand A.
req0_b  input  WIDTH  requester 0 operand B.
req0_cin  input  1  requester 0 carry-in.
req0_ready  output  1  requester 0 accepted this cycle.
req1_valid  input  1  requester 1 has operands.
req1_a  input  WIDTH  requester 1 operand A.
req1_b  input  WIDTH  requester 1 operand B.
req1_cin  input  1  requester 1 carry-in.
req1_ready  output  1  requester 1 accepted this cycle.
res_valid  output  1  result available.
res_sum  output  WIDTH  A+B+cin modulo 2^WIDTH.
res_cout  output  1  carry-out of MSB.
res_id  output  1  requester that issued the result.
res_ready  input  1  consumer accepts result.
busy  output  1  high in RUN or DONE.

Behaviour:
- Reset (async, rst_n=0):
  - state=IDLE; last_grant=1, so requester 0 wins the first tie.
  - res_valid, res_sum, res_cout, res_id, busy all 0.
  - Bit counter, carry flop and shift registers cleared.
  - Deassertion is sampled synchronously.
- States: IDLE, RUN, DONE.
- IDLE:
  - reqN_ready is combinational: state==IDLE && grant==N; at most one ready is high.
  - Grant rule: if only one valid, grant it. If both valid, grant the requester that is not last_grant.
  - On the edge where a valid&&ready handshake occurs:
    - Latch a, b into shift registers; carry flop <= cin; count <= 0.
    - res_id <= granted ID; last_grant <= granted ID; go to RUN.
  - No valid: stay in IDLE.
- RUN:
  - Each cycle the full-adder cell sees a[0], b[0] and the carry flop.
  - Its S shifts into the MSB of the sum register, which shifts right.
  - Operand registers shift right; carry flop <= Cout; count++.
  - When count==WIDTH-1, go to DONE on that edge; the carry flop then holds the final carry.
  - Exactly WIDTH cycles in RUN.
- DONE:
  - res_valid=1; res_sum, res_cout (=carry flop) and res_id held stable while res_valid && !res_ready.
  - On the res_valid && res_ready edge, go to IDLE; res_valid drops next cycle.
  - No new request is accepted in the DONE cycle.
- Latency: a request handshake at edge E0 gives res_valid high after edge E0+WIDTH.
  - Minimum issue interval is WIDTH+2 cycles with res_ready tied high.
- res_sum/res_cout keep their last values after leaving DONE, and are valid only with res_valid.
- Requester behaviour: dropping valid while not granted is legal, and nothing is latched for it. Operands are sampled only on the handshake edge, so later changes have no effect.
- WIDTH=1: RUN lasts one cycle; the result equals the full-adder truth table.
- Arithmetic: {res_cout,res_sum} == a + b + cin, unsigned, WIDTH+1 bits.
- Reset mid-RUN or mid-DONE: immediate return to IDLE with all outputs 0; the in-flight result is discarded, not delivered.
- busy=1 iff state is RUN or DONE.

Test Plan:
- WIDTH=8, req0 a=0xFF b=0x01 cin=0, res_ready=1 → res_valid rises 8 cycles after handshake; sum=0x00, cout=1, id=0.
- req1 a=0x7F b=0x80 cin=1 → sum=0x00, cout=1, id=1; req0_ready stays 0 throughout.
- Both valid continuously from reset with distinct operands → grants alternate 0,1,0,1; each result id and sum match its requester; no starvation over 10 ops.
- DONE with res_ready=0 for 5 cycles → res_valid, res_sum, res_id stable, and both reqN_ready=0. Raising res_ready completes the handshake; IDLE follows one cycle later.
- Assert rst_n=0 at RUN bit 3 of a=0xAA b=0x55 → outputs 0 immediately, no result delivered. A subsequent request 0x12+0x34 cin=0 gives 0x46, cout=0.
- WIDTH=1 build: all 8 (a,b,cin) combinations → {cout,sum} = 00,01,01,10,01,10,10,11 in binary order.
